// File: rtl/ryuki_datatypes.sv
// Shared datatypes for the tracker query path: range query record and arbiter state.
package ryuki_datatypes;

  typedef struct {
    integer start;
    integer finish;
  } range_query;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } tq_arb_state;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot grant of the first request at or after ptr.
module rr_arbiter #(
  parameter int N = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx[PW-1:0]]) begin
        grant[idx[PW-1:0]] = 1'b1;
        found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tracker_query_arbiter.sv
// Time-shares one signal_tracker range query port between several pipeline-stage
// requesters, returning one hit bit per accepted query in round-robin order.
//
// state   | meaning
// IDLE    | offer grant to next requester, latch its range on handshake
// ISSUE   | pulse recalculate_o to the shared tracker
// WAIT    | count down the tracker result latency, capture range_hit_i at zero
// RESPOND | one-cycle resp_valid to the owner, advance round-robin pointer
module tracker_query_arbiter
  import ryuki_datatypes::*;
#(
  parameter int N_REQ   = 3,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0][31:0] req_start,
  input  logic [N_REQ-1:0][31:0] req_end,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       resp_valid,
  output logic                   resp_hit,
  output logic [1:0][31:0]       range_o,
  output logic                   recalculate_o,
  input  logic                   range_hit_i
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  tq_arb_state      state, state_nxt;
  logic [PW-1:0]    rr_ptr, owner, grant_idx;
  logic [N_REQ-1:0] grant;
  logic [3:0]       wait_cnt;
  logic             hit_q;
  logic             handshake;
  range_query       sel;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) grant_idx = PW'(i);
    end
    sel.start  = req_start[grant_idx];
    sel.finish = req_end[grant_idx];
  end

  // rst gating keeps req_ready low while reset is held, even though state is already IDLE
  assign req_ready = (state == IDLE && rst) ? grant : '0;
  assign handshake = |req_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    recalculate_o = 1'b0;
    resp_valid    = '0;
    resp_hit      = 1'b0;
    case (state)
      IDLE: begin
        if (handshake) state_nxt = (sel.start <= sel.finish) ? ISSUE : RESPOND;
      end
      ISSUE: begin
        recalculate_o = 1'b1;
        state_nxt     = WAIT;
      end
      WAIT: begin
        if (wait_cnt == 4'd0) state_nxt = RESPOND;
      end
      RESPOND: begin
        resp_valid[owner] = 1'b1;
        resp_hit          = hit_q;
        state_nxt         = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr   <= '0;
      owner    <= '0;
      wait_cnt <= '0;
      hit_q    <= 1'b0;
      range_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            owner   <= grant_idx;
            range_o <= {sel.start, sel.finish};
            hit_q   <= 1'b0;
          end
        end
        ISSUE: wait_cnt <= 4'(LATENCY - 1);
        WAIT: begin
          if (wait_cnt == 4'd0) hit_q    <= range_hit_i;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        RESPOND: rr_ptr <= (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tracker_query_arbiter.sv
// Bench for tracker_query_arbiter: timeline model checked every cycle plus directed scenarios.
module tb_tracker_query_arbiter;
  localparam int N   = 3;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N-1:0]       req_valid = '0;
  logic [N-1:0][31:0] req_start = '0;
  logic [N-1:0][31:0] req_end   = '0;
  logic [N-1:0]       req_ready, resp_valid;
  logic               resp_hit, recalc, range_hit;
  logic [1:0][31:0]   range_o;
  logic tog = 1'b0, hit_sel = 1'b0, hit_const = 1'b0;
  assign range_hit = hit_sel ? hit_const : tog;

  logic [N-1:0]       aux_valid = '0;
  logic [N-1:0][31:0] aux_start = '0;
  logic [N-1:0][31:0] aux_end   = '0;
  logic [N-1:0]       l1_ready, l1_rv, l15_ready, l15_rv;
  logic               l1_hit, l1_rc, l15_hit, l15_rc;
  logic [1:0][31:0]   l1_range, l15_range;

  tracker_query_arbiter #(.N_REQ(N), .LATENCY(LAT)) u_main (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_start(req_start), .req_end(req_end),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_hit(resp_hit),
    .range_o(range_o), .recalculate_o(recalc), .range_hit_i(range_hit));

  tracker_query_arbiter #(.N_REQ(N), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(aux_valid), .req_start(aux_start), .req_end(aux_end),
    .req_ready(l1_ready), .resp_valid(l1_rv), .resp_hit(l1_hit),
    .range_o(l1_range), .recalculate_o(l1_rc), .range_hit_i(tog));

  tracker_query_arbiter #(.N_REQ(N), .LATENCY(15)) u_l15 (
    .clk(clk), .rst(rst), .req_valid(aux_valid), .req_start(aux_start), .req_end(aux_end),
    .req_ready(l15_ready), .resp_valid(l15_rv), .resp_hit(l15_hit),
    .range_o(l15_range), .recalculate_o(l15_rc), .range_hit_i(tog));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1 tog = ~tog;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tmo(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out at cycle %0d", nm, cyc);
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Timeline model: a handshake at cycle t schedules recalc at t+1, hit sample at
  // t+1+LAT and response at t+2+LAT (empty range: response at t+1, hit 0).
  int   m_ptr = 0, m_owner = 0, m_rc = -1, m_samp = -1, m_resp = -1;
  bit   m_busy = 1'b0;
  logic m_hit = 1'b0;
  logic [63:0] m_range = '0;

  always @(negedge clk) begin
    logic [N-1:0] e_ready, e_rv;
    logic e_rc, e_hit;
    int g;
    e_ready = '0; e_rv = '0; e_rc = 1'b0; e_hit = 1'b0; g = -1;
    if (!rst) begin
      m_busy = 1'b0; m_ptr = 0; m_range = '0; m_hit = 1'b0;
      m_rc = -1; m_samp = -1; m_resp = -1;
    end else begin
      if (!m_busy)
        for (int i = 0; i < N; i++)
          if (g < 0 && req_valid[(m_ptr + i) % N]) g = (m_ptr + i) % N;
      if (g >= 0) e_ready[g] = 1'b1;
      if (cyc == m_rc) e_rc = 1'b1;
      if (cyc == m_samp) m_hit = range_hit;
      if (cyc == m_resp) begin
        e_rv[m_owner] = 1'b1;
        e_hit = m_hit;
      end
    end
    chk("model_req_ready", req_ready, e_ready);
    chk("model_recalc", recalc, e_rc);
    chk("model_resp_valid", resp_valid, e_rv);
    chk("model_resp_hit", resp_hit, e_hit);
    chk("model_range", range_o, m_range);
    if (rst) begin
      if (cyc == m_resp) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % N;
      end
      if (g >= 0) begin
        m_busy  = 1'b1;
        m_owner = g;
        m_range = {req_start[g], req_end[g]};
        if ($signed(req_start[g]) <= $signed(req_end[g])) begin
          m_rc = cyc + 1; m_samp = cyc + 1 + LAT; m_resp = cyc + 2 + LAT;
        end else begin
          m_hit = 1'b0; m_rc = -1; m_samp = -1; m_resp = cyc + 1;
        end
      end
    end
  end

  int hs_cyc[$], hs_who[$], rc_cyc[$], rsp_cyc[$], rsp_who[$];
  logic rsp_h[$];
  logic [N-1:0] rsp_oh[$];
  logic [63:0] rsp_rng[$];
  logic tog_hist [0:8191];
  int l1_rcc = -1, l1_rsp = -1, l1_n = 0, l15_rcc = -1, l15_rsp = -1, l15_n = 0;
  logic l1_h = 1'b0, l15_h = 1'b0;

  always @(negedge clk) begin
    if (cyc < 8192) tog_hist[cyc] = tog;
    if (rst) begin
      if (|req_ready) begin hs_cyc.push_back(cyc); hs_who.push_back(oh2i(req_ready)); end
      if (recalc) rc_cyc.push_back(cyc);
      if (|resp_valid) begin
        rsp_cyc.push_back(cyc); rsp_who.push_back(oh2i(resp_valid));
        rsp_h.push_back(resp_hit); rsp_oh.push_back(resp_valid); rsp_rng.push_back(range_o);
      end
      if (l1_rc) l1_rcc = cyc;
      if (|l1_rv) begin l1_rsp = cyc; l1_h = l1_hit; l1_n++; end
      if (l15_rc) l15_rcc = cyc;
      if (|l15_rv) begin l15_rsp = cyc; l15_h = l15_hit; l15_n++; end
    end
  end

  task automatic clr();
    hs_cyc.delete(); hs_who.delete(); rc_cyc.delete(); rsp_cyc.delete();
    rsp_who.delete(); rsp_h.delete(); rsp_oh.delete(); rsp_rng.delete();
  endtask

  task automatic wait_ready(input int r);
    int n = 0;
    @(negedge clk);
    while (!req_ready[r]) begin
      @(negedge clk);
      n++;
      if (n > 100) begin tmo("ready_wait"); return; end
    end
  endtask

  task automatic request(input int r, input int s, input int e);
    req_start[r] = s; req_end[r] = e; req_valid[r] = 1'b1;
    wait_ready(r);
    @(posedge clk); #1 req_valid[r] = 1'b0;
  endtask

  task automatic wait_rsp(input int want, input string nm);
    int n = 0;
    while (rsp_cyc.size() < want) begin
      @(negedge clk);
      n++;
      if (n > 100) begin tmo(nm); return; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_rr[4] = '{0, 1, 2, 0};
    int exp_bb[3] = '{0, 1, 0};
    int n;

    // reset values, with all requesters already asking
    req_valid = 3'b111;
    req_start[0] = 1;  req_end[0] = 3;
    req_start[1] = 4;  req_end[1] = 8;
    req_start[2] = -5; req_end[2] = -1;
    repeat (2) @(negedge clk);
    chk("reset_ready", req_ready, 3'b000);
    chk("reset_resp_valid", resp_valid, 3'b000);
    chk("reset_hit", resp_hit, 1'b0);
    chk("reset_recalc", recalc, 1'b0);
    chk("reset_range", range_o, 64'h0);

    // round-robin fairness with all three held valid
    @(posedge clk); #1 rst = 1'b1;
    n = 0;
    while (hs_who.size() < 4 && n <= 100) begin @(negedge clk); n++; end
    if (n > 100) tmo("rr_grants");
    @(posedge clk); #1 req_valid = '0;
    wait_rsp(4, "rr_responses");
    chk("rr_grant_count", hs_who.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < hs_who.size())  chk($sformatf("rr_grant%0d", i), hs_who[i], exp_rr[i]);
      if (i < rsp_who.size()) chk($sformatf("rr_resp%0d", i), rsp_who[i], exp_rr[i]);
    end
    repeat (3) @(posedge clk);

    // single valid query on requester 1
    clr();
    #1 hit_sel = 1'b1; hit_const = 1'b1;
    request(1, 10, 14);
    wait_rsp(1, "single_resp");
    repeat (3) @(negedge clk);
    chk("single_rc_count", rc_cyc.size(), 1);
    if (rc_cyc.size() > 0 && hs_cyc.size() > 0) chk("single_rc_cycle", rc_cyc[0] - hs_cyc[0], 1);
    if (rsp_cyc.size() > 0 && hs_cyc.size() > 0) begin
      chk("single_resp_cycle", rsp_cyc[0] - hs_cyc[0], 4);
      chk("single_resp_valid", rsp_oh[0], 3'b010);
      chk("single_resp_hit", rsp_h[0], 1'b1);
      chk("single_range", rsp_rng[0], 64'h0000000a_0000000e);
    end

    // empty range on requester 2: immediate miss, no tracker query
    clr();
    @(posedge clk); #1;
    request(2, 20, 19);
    wait_rsp(1, "empty_resp");
    repeat (5) @(negedge clk);
    chk("empty_rc_count", rc_cyc.size(), 0);
    if (rsp_cyc.size() > 0 && hs_cyc.size() > 0) begin
      chk("empty_resp_cycle", rsp_cyc[0] - hs_cyc[0], 1);
      chk("empty_resp_valid", rsp_oh[0], 3'b100);
      chk("empty_resp_hit", rsp_h[0], 1'b0);
    end

    // reset while waiting on the tracker
    clr();
    @(posedge clk); #1;
    request(0, 3, 7);
    n = 0;
    while (rc_cyc.size() < 1 && n <= 20) begin @(negedge clk); n++; end
    if (n > 20) tmo("rst_rc");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_range", range_o, 64'h0);
    chk("midrst_resp_valid", resp_valid, 3'b000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_no_resp", rsp_cyc.size(), 0);
    clr();
    @(posedge clk); #1;
    request(0, 3, 7);
    wait_rsp(1, "after_rst_resp");
    if (rsp_cyc.size() > 0 && hs_cyc.size() > 0) begin
      chk("after_rst_who", rsp_who[0], 0);
      chk("after_rst_cycle", rsp_cyc[0] - hs_cyc[0], 4);
      chk("after_rst_hit", rsp_h[0], 1'b1);
    end
    repeat (3) @(posedge clk);

    // requester 0 reasserts in its RESPOND cycle while requester 1 waits
    clr();
    #1 hit_sel = 1'b0;
    req_start[0] = 1; req_end[0] = 2; req_valid[0] = 1'b1;
    wait_ready(0);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    req_start[1] = 30; req_end[1] = 40; req_valid[1] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!resp_valid[0] && n <= 20) begin @(negedge clk); n++; end
    if (n > 20) tmo("b2b_resp0");
    #1 req_valid[0] = 1'b1;
    wait_ready(1);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    wait_ready(0);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    wait_rsp(3, "b2b_responses");
    chk("b2b_grant_count", hs_who.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < hs_who.size()) chk($sformatf("b2b_grant%0d", i), hs_who[i], exp_bb[i]);

    // latency sweep against a toggling tracker on LATENCY=1 and LATENCY=15
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin @(posedge clk); #1; end
      aux_start[0] = 0; aux_end[0] = 5; aux_valid[0] = 1'b1;
      n = 0;
      @(negedge clk);
      while (!(l1_ready[0] && l15_ready[0]) && n <= 40) begin @(negedge clk); n++; end
      if (n > 40) tmo("sweep_ready");
      @(posedge clk); #1 aux_valid[0] = 1'b0;
      n = 0;
      while ((l1_n < k + 1 || l15_n < k + 1) && n <= 60) begin @(negedge clk); n++; end
      if (n > 60) tmo("sweep_resp");
      if (l1_rcc >= 0 && l15_rcc >= 0) begin
        chk($sformatf("lat1_resp_cycle%0d", k), l1_rsp - l1_rcc, 2);
        chk($sformatf("lat1_hit%0d", k), l1_h, tog_hist[l1_rcc + 1]);
        chk($sformatf("lat15_resp_cycle%0d", k), l15_rsp - l15_rcc, 16);
        chk($sformatf("lat15_hit%0d", k), l15_h, tog_hist[l15_rcc + 15]);
      end
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
